gb_timer: RTL
=============

Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer peripheral, upstream of the CPU datapath.
- Decodes CPU bus accesses at 0xFF04–0xFF07.
- Runs a free-running divider and a programmable timer.
- Raises a level interrupt request held until the CPU's interrupt logic acknowledges it.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV. TIMA, TMA and TAC occupy BASE_ADDR+1, +2 and +3.
- RD_UNMAPPED, 8'hFF, value driven on rdata when addr is outside the four-register window.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- addr  input  16  CPU bus address (memory address register value).
- wdata  input  8  write data from the CPU data register.
- we  input  1  write strobe, one cycle per write.
- re  input  1  read strobe. Only qualifies nothing; rdata is combinational regardless.
- rdata  output  8  read data for the addressed register.
- irq  output  1  timer interrupt request (level).
- irq_ack  input  1  one-cycle acknowledge from the interrupt controller/CPU.

Behaviour:

Reset (asynchronous, active-high):
- div_cnt[15:0]=0, TIMA=0, TMA=0, TAC=0, state=IDLE, irq=0, prev_tick=0.
- rdata follows from these values (DIV reads 0x00).
- Reset mid-operation aborts any pending reload and clears irq immediately.

Divider:
- div_cnt increments by 1 every clk, wrapping 0xFFFF->0x0000.
- DIV read value is div_cnt[15:8].
- Any write to DIV clears div_cnt to 0 on that edge; wdata is ignored.

Tick source:
- sel bit chosen by TAC[1:0]: 00 -> div_cnt[9], 01 -> div_cnt[3], 10 -> div_cnt[5], 11 -> div_cnt[7].
- tick = TAC[2] & sel bit, evaluated from current register values.
- prev_tick <= tick every cycle.
- TIMA increment event = prev_tick & ~tick (falling edge).
- A DIV write or TAC write that drops tick from 1 to 0 therefore produces one spurious increment. This is required behaviour.

TIMA state machine:
- IDLE:
  - Increment event with TIMA != 0xFF -> TIMA+1, stay IDLE.
  - Increment event with TIMA == 0xFF -> TIMA=0x00, go OVF.
  - A CPU write to TIMA in the same cycle wins over an increment and cancels any overflow.
- OVF (exactly one cycle; TIMA reads 0x00):
  - If TIMA is written this cycle: TIMA=wdata, irq unchanged, go IDLE. The reload is cancelled.
  - Otherwise: TIMA<=TMA, irq<=1, go IDLE. If TMA is written this same cycle, the new wdata is loaded.
- Increment events arriving during OVF are dropped.

Interrupt:
- irq is set only by the OVF->IDLE reload.
- irq is cleared by irq_ack.
- Set and ack in the same cycle -> irq stays 1 (set wins).

Register access:
- Writes take effect on the clk edge where we=1.
- TMA and TAC writes apply in IDLE and OVF. Only TAC[2:0] is stored.
- rdata is combinational from addr:
  - DIV -> div_cnt[15:8].
  - TIMA -> TIMA.
  - TMA -> TMA.
  - TAC -> {5'b11111, TAC[2:0]}.
  - Any other address -> RD_UNMAPPED.
- re does not gate rdata and has no side effects.

Width rules:
- All register arithmetic is 8-bit modulo.
- div_cnt is 16-bit modulo.

Test Plan:
1. Reset, then read each register:
   - DIV=0x00, TIMA=0x00, TMA=0x00, TAC=0xF8, addr 0xFF08 -> 0xFF, irq=0.
2. TAC=0x05 (bit 3, enabled), TIMA=0x00, run 64 clks from DIV write:
   - TIMA=0x04 (increments every 16 clks).
   - DIV reads 0x01 after 256 clks.
3. TMA=0xAB, TIMA=0xFF, TAC=0x05, run to overflow:
   - TIMA reads 0x00 for exactly one cycle, then 0xAB.
   - irq rises on the same edge and stays 1 until an irq_ack pulse, then 0.
4. Overflow, then write TIMA=0x42 during the OVF cycle:
   - TIMA=0x42, irq stays 0, no TMA reload.
   - Separately, write TMA=0x77 during OVF -> TIMA=0x77, irq=1.
5. TAC=0x05 with div_cnt[3]=1, write DIV:
   - TIMA increments by 1 on the following edge, DIV=0x00.
   - Repeat with TAC write 0x05->0x01 while div_cnt[3]=1 -> one increment.
6. irq=1 and a new overflow reload coincides with irq_ack -> irq remains 1.
   - Assert rst mid-OVF -> TIMA=0, irq=0 immediately, no reload afterward.

Source files
------------

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer peripheral: free-running divider, programmable
// timer with one-cycle overflow/reload phase, and a level interrupt request.
module gb_timer #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF04,
  parameter logic [7:0]  RD_UNMAPPED = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic        irq,
  input  logic        irq_ack
);

  // state    | meaning
  // ST_IDLE  | counting; falling tick edges increment TIMA
  // ST_OVF   | TIMA wrapped last edge, reads 0x00; reload from TMA next edge
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OVF  = 1'b1;

  localparam logic [15:0] ADDR_DIV  = BASE_ADDR;
  localparam logic [15:0] ADDR_TIMA = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_TMA  = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_TAC  = BASE_ADDR + 16'd3;

  logic [15:0] div_q, div_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [0:0]  state_q, state_d;
  logic        irq_q, irq_d;
  logic        prev_tick_q, prev_tick_d;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic sel_bit, tick, inc_ev, reload;

  // The read strobe has no side effects; rdata is purely address-decoded.
  logic unused_re;
  assign unused_re = re;

  assign wr_div  = we && (addr == ADDR_DIV);
  assign wr_tima = we && (addr == ADDR_TIMA);
  assign wr_tma  = we && (addr == ADDR_TMA);
  assign wr_tac  = we && (addr == ADDR_TAC);

  always_comb begin
    case (tac_q[1:0])
      2'b00:   sel_bit = div_q[9];
      2'b01:   sel_bit = div_q[3];
      2'b10:   sel_bit = div_q[5];
      default: sel_bit = div_q[7];
    endcase
    tick   = tac_q[2] & sel_bit;
    inc_ev = prev_tick_q & ~tick;
  end

  always_comb begin
    div_d       = wr_div ? 16'h0000 : div_q + 16'd1;
    tma_d       = wr_tma ? wdata : tma_q;
    tac_d       = wr_tac ? wdata[2:0] : tac_q;
    prev_tick_d = tick;
    tima_d      = tima_q;
    state_d     = ST_IDLE;
    reload      = 1'b0;
    case (state_q)
      ST_OVF: begin
        // A TIMA write during the overflow cycle cancels the reload and the irq.
        if (wr_tima) begin
          tima_d = wdata;
        end else begin
          tima_d = tma_d;
          reload = 1'b1;
        end
      end
      default: begin
        if (wr_tima) begin
          tima_d = wdata;
        end else if (inc_ev) begin
          tima_d = tima_q + 8'd1;
          if (tima_q == 8'hFF) state_d = ST_OVF;
        end
      end
    endcase
    if (reload)       irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
    else              irq_d = irq_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= 16'h0000;
      tima_q      <= 8'h00;
      tma_q       <= 8'h00;
      tac_q       <= 3'b000;
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      prev_tick_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      tima_q      <= tima_d;
      tma_q       <= tma_d;
      tac_q       <= tac_d;
      state_q     <= state_d;
      irq_q       <= irq_d;
      prev_tick_q <= prev_tick_d;
    end
  end

  always_comb begin
    if (addr == ADDR_DIV)       rdata = div_q[15:8];
    else if (addr == ADDR_TIMA) rdata = tima_q;
    else if (addr == ADDR_TMA)  rdata = tma_q;
    else if (addr == ADDR_TAC)  rdata = {5'b11111, tac_q};
    else                        rdata = RD_UNMAPPED;
  end

  assign irq = irq_q;

endmodule
